button_events: RTL and testbench
================================

# button_events

Converts the debounced trigger/button level from the input debouncer into discrete one-cycle game events: press, release, hold and auto-repeat. It also keeps a wrapping count of fire events. It sits between the debouncer output and the game controller, so the shooting logic consumes clean pulses rather than levels. All outputs are registered and synchronous to the debouncer's clock.

## Interface
- HOLD_CYCLES, 25_000_000: cycles from the press pulse to the hold pulse; must be ≥ 2.
- REPEAT_CYCLES, 5_000_000: cycles from the hold pulse to the first repeat, and between repeats; must be ≥ 2.
- CNT_W, 25: timer width; must hold max(HOLD_CYCLES, REPEAT_CYCLES) − 1.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- level  in  1  debounced button level, already synchronous to clock.
- enable  in  1  high = events allowed.
- press  out  1  one-cycle pulse on an accepted press.
- release  out  1  one-cycle pulse on leaving the pressed/held condition.
- hold  out  1  one-cycle pulse when the hold threshold is reached.
- repeat  out  1  one-cycle auto-repeat pulse.
- fire  out  1  press | repeat.
- held  out  1  level; high while in HELD.
- fire_count  out  8  number of fire pulses, wraps 255 → 0.

## Operation
- One clock; reset is asynchronous and active-high.
- States:
  - WAIT_LOW: armed only after level is seen low.
  - IDLE
  - PRESSED
  - HELD
- Reset: state WAIT_LOW, timer 0, every output 0.
- Precedence at each edge, highest first: `enable`=0, then the level change, then the timer threshold.
- WAIT_LOW → IDLE when enable=1 and level=0. A button held through reset or re-enable never produces a press.
- IDLE, level=1, enable=1 → PRESSED. Press and fire go high in the next cycle. Timer is 0 in that cycle. fire_count is incremented.
- PRESSED, level=1:
  - if timer = HOLD_CYCLES−1: → HELD, hold pulse next cycle, timer cleared to 0.
  - otherwise timer +1.
- HELD, level=1:
  - if timer = REPEAT_CYCLES−1: repeat and fire pulse next cycle, fire_count +1, timer cleared.
  - otherwise timer +1.
- PRESSED or HELD, level=0 → IDLE, release pulse next cycle, timer cleared.
- enable=0:
  - from IDLE, WAIT_LOW, PRESSED or HELD → WAIT_LOW, timer cleared.
  - a release pulse is issued only when leaving PRESSED or HELD, so press and release always pair.
  - no press, hold or repeat is issued while enable=0.
- Boundary rules:
  - release and a timer threshold on the same edge: release only, no hold or repeat.
  - release and hold are never high in the same cycle.
  - fire_count wraps silently.
- Asserting reset mid-event clears everything immediately. No release pulse is issued.

## Timing
- Every pulse is exactly 1 cycle wide.
- Latency from the sampling edge to the output is 1 cycle.
- Taking cycle t0 as the press-pulse cycle, with level held high:
  - hold at t0+HOLD_CYCLES;
  - repeats at t0+HOLD_CYCLES+k·REPEAT_CYCLES, for k ≥ 1.
- level low sampled at the edge ending cycle t0+n−1 → release in cycle t0+n.
- held rises in the same cycle as hold and falls in the same cycle as release.
- fire_count updates in the same cycle as the fire pulse (registered together).
- Minimum spacing between two presses: release cycle plus one IDLE cycle with level high.

## Test plan
All scenarios use HOLD_CYCLES=8, REPEAT_CYCLES=3.
- **Reset with button held.** Hold level=1 through and after reset, 10 cycles → no pulses, fire_count=0. Then level 0 for 2 cycles and 1 again → press 1 cycle after the first high sample, fire_count=1.
- **Short press.** Level high for 5 sampled edges → press at t0, release at t0+5, no hold or repeat, fire_count +1.
- **Long press.** Level high for 20 sampled edges:
  - press at t0;
  - hold and held rise at t0+8;
  - repeat and fire at t0+11, t0+14, t0+17;
  - release and held fall at t0+20;
  - fire_count +4.
- **Release on the hold edge.** Level goes low on the edge where timer=7 → release at t0+8, hold never asserted, held stays 0.
- **Enable drop while held.** enable=0 at t0+12 → release next cycle, no further repeats. Re-enable with level still high → no press until level goes low then high.
- **Counter wrap.** 256 short presses → fire_count returns to 0. The 257th press → fire_count=1.

Source files
------------

// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/hold/repeat events
// and keeps a wrapping count of fire pulses (press or repeat).
module button_events #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_level,
    input  logic       i_enable,
    output logic       o_press,
    output logic       o_release,
    output logic       o_hold,
    output logic       o_repeat,
    output logic       o_fire,
    output logic       o_held,
    output logic [7:0] o_fire_count
);

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_press;
    logic             r_release;
    logic             r_hold;
    logic             r_repeat;
    logic             r_fire;
    logic             r_held;
    logic [7:0]       r_fire_count;

    logic w_active;
    logic w_hold_due;
    logic w_repeat_due;

    assign w_active     = (r_state == ST_PRESSED) || (r_state == ST_HELD);
    assign w_hold_due   = (r_timer == HOLD_LAST);
    assign w_repeat_due = (r_timer == REPEAT_LAST);

    // NOTE: every state and output register is written with <= so all of them
    // update together from the same pre-edge values, which keeps pulses aligned.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_WAIT_LOW;
            r_timer      <= '0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_hold       <= 1'b0;
            r_repeat     <= 1'b0;
            r_fire       <= 1'b0;
            r_held       <= 1'b0;
            r_fire_count <= 8'd0;
        end else begin
            r_press  <= 1'b0;
            r_release <= 1'b0;
            r_hold   <= 1'b0;
            r_repeat <= 1'b0;
            r_fire   <= 1'b0;

            if (!i_enable) begin
                // Closing an open press with a release keeps press/release paired.
                r_release <= w_active;
                r_held    <= 1'b0;
                r_state   <= ST_WAIT_LOW;
                r_timer   <= '0;
            end else begin
                case (r_state)
                    ST_WAIT_LOW: begin
                        if (!i_level) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (i_level) begin
                            r_state      <= ST_PRESSED;
                            r_timer      <= '0;
                            r_press      <= 1'b1;
                            r_fire       <= 1'b1;
                            r_fire_count <= r_fire_count + 8'd1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!i_level) begin
                            r_state   <= ST_IDLE;
                            r_timer   <= '0;
                            r_release <= 1'b1;
                        end else if (w_hold_due) begin
                            r_state <= ST_HELD;
                            r_timer <= '0;
                            r_hold  <= 1'b1;
                            r_held  <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!i_level) begin
                            r_state   <= ST_IDLE;
                            r_timer   <= '0;
                            r_release <= 1'b1;
                            r_held    <= 1'b0;
                        end else if (w_repeat_due) begin
                            r_timer      <= '0;
                            r_repeat     <= 1'b1;
                            r_fire       <= 1'b1;
                            r_fire_count <= r_fire_count + 8'd1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_LOW;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_hold       = r_hold;
    assign o_repeat     = r_repeat;
    assign o_fire       = r_fire;
    assign o_held       = r_held;
    assign o_fire_count = r_fire_count;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: hand-computed vector table, directed
// multi-cycle sequences and random stimulus against a timestamp-based reference.
module tb_button_events;

    localparam int HOLD  = 8;
    localparam int REP   = 3;
    localparam int CW    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic       en;
    logic       o_press, o_release, o_hold, o_repeat, o_fire, o_held;
    logic [7:0] o_fire_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_events #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (CW)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_level     (lv),
        .i_enable    (en),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_hold      (o_hold),
        .o_repeat    (o_repeat),
        .o_fire      (o_fire),
        .o_held      (o_held),
        .o_fire_count(o_fire_count)
    );

    // Reference: a press episode is timed by its age relative to the press pulse.
    bit         m_armed;
    bit         m_active;
    int         m_age;
    logic [7:0] m_count;
    logic       m_press, m_release, m_hold, m_repeat;

    task automatic model_reset();
        m_armed = 0; m_active = 0; m_age = 0; m_count = 8'd0;
        m_press = 0; m_release = 0; m_hold = 0; m_repeat = 0;
    endtask

    task automatic model_edge(input logic l, input logic e);
        m_press = 0; m_release = 0; m_hold = 0; m_repeat = 0;
        if (!e) begin
            m_release = m_active;
            m_active  = 0;
            m_armed   = 0;
        end else if (!m_armed) begin
            if (!l) m_armed = 1;
        end else if (!m_active) begin
            if (l) begin
                m_active = 1;
                m_age    = 0;
                m_press  = 1;
                m_count  = m_count + 8'd1;
            end
        end else if (!l) begin
            m_active  = 0;
            m_release = 1;
        end else begin
            m_age = m_age + 1;
            if (m_age == HOLD) m_hold = 1;
            if (m_age > HOLD && ((m_age - HOLD) % REP) == 0) begin
                m_repeat = 1;
                m_count  = m_count + 8'd1;
            end
        end
    endtask

    function automatic logic [13:0] model_vec();
        logic held_now;
        held_now = m_active && (m_age >= HOLD);
        return {m_press, m_release, m_hold, m_repeat, m_press | m_repeat, held_now, m_count};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {o_press, o_release, o_hold, o_repeat, o_fire, o_held, o_fire_count};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {p,r,h,rp,f,hd,cnt}=%b_%h required %b_%h",
                     name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    // One clock edge with the given inputs, compared to the reference.
    task automatic step(input logic l, input logic e, input string name);
        lv = l;
        en = e;
        @(posedge clk);
        model_edge(l, e);
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    task automatic do_reset(input logic l);
        rst = 1'b1;
        lv  = l;
        en  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 14'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       lv;
        logic       en;
        logic       press;
        logic       rel;
        logic       hold;
        logic       rpt;
        logic       held;
        logic [7:0] cnt;
    } vec_t;

    vec_t       tbl[29];
    logic [7:0] cnt0;
    bit [31:0]  hold_mask, rep_mask, rel_mask, held_mask;
    int         run_len;
    logic       rl;
    logic       re;

    initial begin
        rst = 1'b0;
        lv  = 1'b1;
        en  = 1'b1;

        // Reset with button held, then short press, then release on the hold edge.
        for (int i = 0; i < 10; i++) tbl[i] = '{1, 1, 0, 0, 0, 0, 0, 8'd0};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 8'd0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 8'd0};
        tbl[12] = '{1, 1, 1, 0, 0, 0, 0, 8'd1};
        for (int i = 13; i < 17; i++) tbl[i] = '{1, 1, 0, 0, 0, 0, 0, 8'd1};
        tbl[17] = '{0, 1, 0, 1, 0, 0, 0, 8'd1};
        tbl[18] = '{0, 1, 0, 0, 0, 0, 0, 8'd1};
        tbl[19] = '{1, 1, 1, 0, 0, 0, 0, 8'd2};
        for (int i = 20; i < 27; i++) tbl[i] = '{1, 1, 0, 0, 0, 0, 0, 8'd2};
        tbl[27] = '{0, 1, 0, 1, 0, 0, 0, 8'd2};
        tbl[28] = '{0, 1, 0, 0, 0, 0, 0, 8'd2};

        do_reset(1'b1);
        for (int i = 0; i < 29; i++) begin
            lv = tbl[i].lv;
            en = tbl[i].en;
            @(posedge clk);
            model_edge(tbl[i].lv, tbl[i].en);
            #1;
            check($sformatf("table_row%0d", i), dut_vec(),
                  {tbl[i].press, tbl[i].rel, tbl[i].hold, tbl[i].rpt,
                   tbl[i].press | tbl[i].rpt, tbl[i].held, tbl[i].cnt});
        end

        // Long press: 20 high samples then release.
        cnt0 = o_fire_count;
        hold_mask = 0; rep_mask = 0; rel_mask = 0; held_mask = 0;
        for (int k = 0; k <= 20; k++) begin
            step((k < 20), 1'b1, $sformatf("long_k%0d", k));
            if (o_hold)    hold_mask[k] = 1'b1;
            if (o_repeat)  rep_mask[k]  = 1'b1;
            if (o_release) rel_mask[k]  = 1'b1;
            if (o_held)    held_mask[k] = 1'b1;
        end
        check("long_hold_at", hold_mask[13:0], 14'(1 << 8));
        check("long_rep_at", rep_mask[19:6], 14'(rep_mask[19:6] & 14'h3FFF) & 14'h3FFF);
        check("long_rep_mask", {rep_mask[19:8], 2'b00}, {12'b0010_0100_1000, 2'b00});
        check("long_release_at", {rel_mask[20:8], 1'b0}, {13'b1_0000_0000_0000, 1'b0});
        check("long_held_span", held_mask[20:7], 14'b00_1111_1111_1111 << 1);
        check("long_count_delta", {6'd0, o_fire_count - cnt0}, 14'd4);
        step(1'b0, 1'b1, "long_idle");

        // Enable drop while held.
        for (int k = 0; k <= 12; k++) step(1'b1, 1'b1, $sformatf("endrop_k%0d", k));
        step(1'b1, 1'b0, "endrop_release");
        check("endrop_release_now", {13'd0, o_release}, 14'd1);
        repeat (3) step(1'b1, 1'b0, "endrop_disabled");
        cnt0 = o_fire_count;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, "reenable_high");
            check("reenable_no_press", {13'd0, o_press | o_repeat}, 14'd0);
        end
        step(1'b0, 1'b1, "reenable_low");
        step(1'b1, 1'b1, "reenable_press");
        check("reenable_press_now", {o_press, 5'd0, o_fire_count}, {1'b1, 5'd0, cnt0 + 8'd1});
        step(1'b0, 1'b1, "reenable_release");

        // Asynchronous reset in the middle of a held press: no release pulse.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, "midrst_hold");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_immediate", dut_vec(), 14'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, "midrst_after");

        // Counter wrap after exactly 256 presses from a fresh reset.
        do_reset(1'b0);
        step(1'b0, 1'b1, "wrap_arm");
        for (int n = 0; n < 256; n++) begin
            step(1'b1, 1'b1, "wrap_press");
            step(1'b0, 1'b1, "wrap_release");
        end
        check("wrap_to_zero", {6'd0, o_fire_count}, 14'd0);
        step(1'b1, 1'b1, "wrap_257");
        check("wrap_257_count", {6'd0, o_fire_count}, 14'd1);
        step(1'b0, 1'b1, "wrap_257_release");

        // Random runs of level, with occasional enable drops.
        run_len = 0;
        rl = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (run_len == 0) begin
                rl      = $urandom_range(1, 0) == 1;
                run_len = $urandom_range(30, 1);
            end
            run_len--;
            re = ($urandom_range(99, 0) >= 4);
            step(rl, re, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
